// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults and select-width helper for the N:1 mux
package mux_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

    // A channel index needs at least one bit even when clog2 would give zero.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          grant_valid
);

    logic [SW:0] idx;

    // Walk ptr, ptr+1, ... wrapping at N; the first valid channel wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (SW + 1)'(i);
            if (idx >= (SW + 1)'(N)) begin
                idx = idx - (SW + 1)'(N);
            end
            for (int k = 0; k < N; k++) begin
                if (!grant_valid && idx == (SW + 1)'(k) && valid[k]) begin
                    grant_valid = 1'b1;
                    grant       = SW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - N:1 registered mux with manual or round-robin channel grant
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    parameter  int W  = DEFAULT_W,
    localparam int SW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_ch
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] arb_grant;
    logic          arb_valid;
    logic [SW-1:0] grant;
    logic          grant_valid;
    logic          load_en;
    logic          xfer;
    logic [W-1:0]  grant_data;

    rr_arbiter #(.N(N)) u_arb (
        .valid       (in_valid),
        .ptr         (ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign load_en = !out_valid || out_ready;

    // Manual mode grants sel even without in_valid, so in_ready never waits on the source.
    always_comb begin
        grant       = mode ? arb_grant : sel;
        grant_valid = mode ? arb_valid : (int'(sel) < N);
        in_ready    = '0;
        xfer        = 1'b0;
        grant_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SW'(k)) begin
                in_ready[k] = !rst && grant_valid && load_en;
                xfer        = !rst && grant_valid && load_en && in_valid[k];
                grant_data  = in_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= grant_data;
                out_ch   <= grant;
                if (mode) begin
                    ptr <= (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - self-checking bench for mux_nx1_rr
module tb_mux_nx1_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic           mode;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_ch;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;

    int m_valid = 0, m_data = 0, m_ch = 0, m_ptr = 0;
    int n_valid = 0, n_data = 0, n_ch = 0, n_ptr = 0;

    always #5 clk = ~clk;

    mux_nx1_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: at most one channel granted, chosen by sel or by a circular scan from the pointer.
    always @(negedge clk) begin
        int  g;
        bit  gv;
        bit  load;
        int  exp_ready;
        bit  take;
        load = (m_valid == 0) || (out_ready == 1'b1);
        gv = 1'b0;
        g  = 0;
        if (!rst) begin
            if (!mode) begin
                if (sel < N) begin
                    gv = 1'b1;
                    g  = sel;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!gv && in_valid[(m_ptr + i) % N]) begin
                        gv = 1'b1;
                        g  = (m_ptr + i) % N;
                    end
                end
            end
        end
        exp_ready = (gv && load) ? (1 << g) : 0;
        take      = gv && load && in_valid[g];
        if (chk_en) begin
            check("model_in_ready", 32'(in_ready), exp_ready);
            check("model_out_valid", 32'(out_valid), m_valid);
            if (m_valid != 0) begin
                check("model_out_data", 32'(out_data), m_data);
                check("model_out_ch", 32'(out_ch), m_ch);
            end
        end
        n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_ptr = m_ptr;
        if (rst) begin
            n_valid = 0; n_data = 0; n_ch = 0; n_ptr = 0;
        end else if (load) begin
            n_valid = take;
            if (take) begin
                n_data = in_data[g*W +: W];
                n_ch   = g;
                if (mode) n_ptr = (g + 1) % N;
            end
        end
    end

    always @(posedge clk) begin
        m_valid <= n_valid;
        m_data  <= n_data;
        m_ch    <= n_ch;
        m_ptr   <= n_ptr;
    end

    task automatic step(input bit r, input bit md, input int s, input logic [N-1:0] v,
                        input bit ordy, input int base);
        @(posedge clk);
        #1;
        rst       = r;
        mode      = md;
        sel       = SW'(s);
        in_valid  = v;
        out_ready = ordy;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(base + k);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1; in_data = '0;
        step(1, 0, 0, 4'b0000, 1, 0);
        step(1, 0, 0, 4'b0000, 1, 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_out_ch", 32'(out_ch), 0);
        check("reset_in_ready", 32'(in_ready), 0);
        chk_en = 1'b1;

        step(0, 0, 2, 4'b0100, 1, 'hA3);
        check("manual_in_ready", 32'(in_ready), 'b0100);
        step(0, 0, 2, 4'b0000, 1, 'h10);
        check("manual_out_data", 32'(out_data), 'hA5);
        check("manual_out_ch", 32'(out_ch), 2);
        check("manual_out_valid", 32'(out_valid), 1);
        check("manual_ready_no_valid", 32'(in_ready), 'b0100);

        step(0, 0, 1, 4'b0010, 1, 'h20);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 4'b0010, 0, 'h30);
            check("bp_hold_data", 32'(out_data), 'h21);
            check("bp_hold_ch", 32'(out_ch), 1);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        step(0, 0, 1, 4'b0010, 1, 'h40);
        check("bp_release_ready", 32'(in_ready), 'b0010);
        step(0, 0, 1, 4'b0000, 1, 0);
        check("bp_no_bubble_data", 32'(out_data), 'h41);
        check("bp_no_bubble_valid", 32'(out_valid), 1);

        step(0, 1, 0, 4'b1111, 1, 'h50);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 4'b1111, 1, 'h50);
            check("rr_fair_ch", 32'(out_ch), i % 4);
            check("rr_fair_data", 32'(out_data), 'h50 + (i % 4));
        end

        step(0, 1, 0, 4'b0010, 1, 'h60);
        check("rr_skip_ready", 32'(in_ready), 'b0010);
        step(0, 1, 0, 4'b1001, 1, 'h70);
        check("rr_skip_data", 32'(out_data), 'h61);
        check("rr_wrap_ready", 32'(in_ready), 'b1000);
        step(0, 1, 0, 4'b1111, 1, 'h80);
        check("rr_wrap_ch", 32'(out_ch), 3);
        check("rr_wrap_data", 32'(out_data), 'h73);
        check("rr_after_wrap_ready", 32'(in_ready), 'b0001);

        step(1, 1, 0, 4'b1111, 1, 'h88);
        check("rst_mid_ready", 32'(in_ready), 0);
        check("rst_mid_held", 32'(out_data), 'h80);
        step(0, 1, 0, 4'b1111, 1, 'h90);
        check("rst_drop_valid", 32'(out_valid), 0);
        check("rst_drop_data", 32'(out_data), 0);
        check("rst_drop_ch", 32'(out_ch), 0);
        check("rst_rr_restart", 32'(in_ready), 'b0001);
        step(0, 1, 0, 4'b0000, 1, 0);
        check("rst_rr_first_data", 32'(out_data), 'h90);

        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 99) == 0, 1'($urandom), int'($urandom_range(0, 3)),
                 4'($urandom), $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 The block SHALL have parameter N, default 4, number of input channels (N >= 2).
REQ-002 The block SHALL have parameter W, default 8, data width per channel.
REQ-003 The block SHALL have derived constant SW = max(1, clog2(N)), select/channel-index width.
REQ-004 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port in_data, input, N*W, channel k at bits [k*W +: W].
REQ-007 The block SHALL have port in_valid, input, N, per-channel valid.
REQ-008 The block SHALL have port in_ready, output, N, per-channel ready.
REQ-009 The block SHALL have port sel, input, SW, manual channel select.
REQ-010 The block SHALL have port mode, input, 1, 0 = manual select, 1 = round-robin.
REQ-011 The block SHALL have port out_data, output, W, registered selected data.
REQ-012 The block SHALL have port out_valid, output, 1, out_data holds an unconsumed word.
REQ-013 The block SHALL have port out_ready, input, 1, downstream accepts when high with out_valid.
REQ-014 The block SHALL have port out_ch, output, SW, source channel of out_data.

Function
REQ-015 Output register load_en SHALL equal (!out_valid || out_ready).
REQ-016 At most one channel SHALL be granted per cycle; in_ready[g] = load_en for granted g, all other in_ready bits 0.
REQ-017 Manual mode (mode=0): g SHALL equal sel when sel < N; if sel >= N, no grant and in_ready = 0.
REQ-018 Manual mode: in_ready[sel] SHALL be asserted regardless of in_valid[sel] (combinational, from load_en only).
REQ-019 RR mode (mode=1): g SHALL be the first k with in_valid[k]=1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1; no valid channel -> no grant.
REQ-020 Input transfer SHALL occur when in_valid[g] && in_ready[g]; on the next edge out_data <= in_data[g], out_ch <= g, out_valid <= 1.
REQ-021 If load_en=1 and no transfer occurs, out_valid SHALL go to 0 on the next edge; out_data and out_ch SHALL hold.
REQ-022 Latency SHALL be exactly 1 cycle input-to-output; sustained throughput 1 word/cycle while out_ready=1.
REQ-023 Simultaneous output consume and input transfer in one cycle SHALL replace the word with no bubble.
REQ-024 RR pointer ptr SHALL update to (g+1) mod N only on an RR-mode transfer; wrap N-1 -> 0; otherwise hold.
REQ-025 Mode or sel changes SHALL take effect in the same cycle's grant and SHALL NOT alter a word already held in the output register.
REQ-026 When out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL remain stable and in_ready SHALL be 0.

Reset
REQ-027 On clk rising edge with rst=1: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-028 During rst=1, in_ready SHALL be 0 and no transfer SHALL be recorded; reset mid-stream SHALL drop the held word.

Structure
REQ-029 Package mux_pkg SHALL hold default N, W and the SW derivation function.
REQ-030 Round-robin grant logic (in_valid, ptr -> grant, grant_valid) SHALL be sub-module rr_arbiter; datapath and ptr register stay in mux_nx1_rr.

Verification (N=4, W=8)
REQ-031 Manual: mode=0, sel=2, in_data[2]=8'hA5, in_valid=4'b0100, out_ready=1 -> next cycle out_data=A5, out_ch=2, out_valid=1.
REQ-032 Backpressure: output held with out_ready=0 for 3 cycles -> out_data/out_ch stable, in_ready=0; release -> next word loaded in same cycle as consume.
REQ-033 RR fairness: in_valid=4'b1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-034 RR skip/wrap: ptr=3, in_valid=4'b0010 -> grant 1, ptr becomes 2; then in_valid=4'b1001 -> grant 3, ptr wraps to 0.
REQ-035 Reset mid-operation: out_valid=1, assert rst one cycle -> out_valid=0, out_data=0, out_ch=0, next RR grant starts at channel 0.
REQ-036 Randomised self-check: random mode/sel/in_valid/out_ready, 1000 cycles -> every accepted word matches in_data of its out_ch, none lost or duplicated.
